// File: rtl/forward_propper_seq_if.sv
// Stream interface for the sequential forward-pass neuron: (p, w, bias, last)
// beats in over valid/ready, activation results out over valid/ready.
interface forward_propper_seq_if #(
    parameter int CNTW = 5
);
    logic            fp1_in_valid;
    logic            fp1_in_ready;
    logic [31:0]     fp1_p;
    logic [31:0]     fp1_w;
    logic [31:0]     fp1_bias;
    logic            fp1_last;
    logic            fp1_out_valid;
    logic            fp1_out_ready;
    logic [31:0]     fp1_a;
    logic [63:0]     fp1_z;
    logic            fp1_active;
    logic [CNTW-1:0] fp1_count;
    logic            fp1_trunc;

    modport master (
        output fp1_in_valid, fp1_p, fp1_w, fp1_bias, fp1_last, fp1_out_ready,
        input  fp1_in_ready, fp1_out_valid, fp1_a, fp1_z, fp1_active, fp1_count, fp1_trunc
    );

    modport slave (
        input  fp1_in_valid, fp1_p, fp1_w, fp1_bias, fp1_last, fp1_out_ready,
        output fp1_in_ready, fp1_out_valid, fp1_a, fp1_z, fp1_active, fp1_count, fp1_trunc
    );
endinterface

// File: rtl/forward_propper_seq.sv
// Sequential forward-pass neuron: accumulates bias + sum(p*w) over a beat stream,
// then returns the ReLU activation, the pre-activation and the ReLU-active flag.
module forward_propper_seq #(
    parameter int FRAC   = 16,
    parameter int MAX_IN = 16,
    parameter int CNTW   = 5
) (
    input  logic                 fp1_clk,
    input  logic                 fp1_rst_n,
    forward_propper_seq_if.slave bus
);
    localparam int ACCW = 64 + CNTW;
    localparam logic [CNTW-1:0] MAX_CNT = CNTW'(MAX_IN);
    localparam logic signed [ACCW-1:0] Z_MAX = {{(CNTW+1){1'b0}}, {63{1'b1}}};
    localparam logic signed [ACCW-1:0] Z_MIN = {{(CNTW+1){1'b1}}, {63{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ACT,
        OUT
    } state_t;

    state_t                 state_q, state_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [CNTW-1:0]        count_q, count_d;
    logic                   trunc_q, trunc_d;
    logic [31:0]            a_q, a_d;
    logic [63:0]            z_q, z_d;
    logic                   active_q, active_d;
    logic [CNTW-1:0]        outCount_q, outCount_d;
    logic                   outTrunc_q, outTrunc_d;
    logic                   outValid_q, outValid_d;

    logic                   inReady;
    logic [CNTW-1:0]        nextCount;
    logic signed [63:0]     prod;
    logic signed [ACCW-1:0] prodAcc;
    logic signed [ACCW-1:0] biasAcc;
    logic signed [ACCW-1:0] shifted;
    logic signed [63:0]     zSat;
    logic                   zPos;
    logic [31:0]            aVal;

    // The accumulator carries CNTW guard bits, so only the final shift can overflow 64 bits.
    always_comb begin
        prod    = $signed({{32{bus.fp1_p[31]}}, bus.fp1_p}) * $signed({{32{bus.fp1_w[31]}}, bus.fp1_w});
        prodAcc = {{CNTW{prod[63]}}, prod};
        biasAcc = {{(ACCW-32){bus.fp1_bias[31]}}, bus.fp1_bias} << FRAC;
        shifted = acc_q >>> FRAC;
        if (shifted > Z_MAX) begin
            zSat = 64'sh7FFF_FFFF_FFFF_FFFF;
        end else if (shifted < Z_MIN) begin
            zSat = 64'sh8000_0000_0000_0000;
        end else begin
            zSat = shifted[63:0];
        end
        zPos = (zSat > 64'sh0);
        aVal = 32'h0;
        if (zPos) begin
            aVal = (zSat > 64'sh7FFF_FFFF) ? 32'h7FFF_FFFF : zSat[31:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        trunc_d    = trunc_q;
        a_d        = a_q;
        z_d        = z_q;
        active_d   = active_q;
        outCount_d = outCount_q;
        outTrunc_d = outTrunc_q;
        outValid_d = outValid_q;
        inReady    = 1'b0;
        nextCount  = count_q + CNTW'(1);
        case (state_q)
            IDLE: begin
                inReady = 1'b1;
                if (bus.fp1_in_valid) begin
                    acc_d   = biasAcc + prodAcc;
                    count_d = CNTW'(1);
                    trunc_d = 1'b0;
                    if (bus.fp1_last || MAX_CNT == CNTW'(1)) begin
                        state_d = ACT;
                        trunc_d = !bus.fp1_last;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                inReady = 1'b1;
                if (bus.fp1_in_valid) begin
                    acc_d   = acc_q + prodAcc;
                    count_d = nextCount;
                    if (bus.fp1_last || nextCount == MAX_CNT) begin
                        state_d = ACT;
                        trunc_d = !bus.fp1_last;
                    end
                end
            end
            ACT: begin
                z_d        = zSat;
                a_d        = aVal;
                active_d   = zPos;
                outCount_d = count_q;
                outTrunc_d = trunc_q;
                state_d    = OUT;
            end
            OUT: begin
                // Results were registered in ACT; valid follows one cycle later.
                if (!outValid_q) begin
                    outValid_d = 1'b1;
                end else if (bus.fp1_out_ready) begin
                    outValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge fp1_clk) begin
        if (!fp1_rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            trunc_q    <= 1'b0;
            a_q        <= '0;
            z_q        <= '0;
            active_q   <= 1'b0;
            outCount_q <= '0;
            outTrunc_q <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            trunc_q    <= trunc_d;
            a_q        <= a_d;
            z_q        <= z_d;
            active_q   <= active_d;
            outCount_q <= outCount_d;
            outTrunc_q <= outTrunc_d;
            outValid_q <= outValid_d;
        end
    end

    assign bus.fp1_in_ready  = inReady;
    assign bus.fp1_out_valid = outValid_q;
    assign bus.fp1_a         = a_q;
    assign bus.fp1_z         = z_q;
    assign bus.fp1_active    = active_q;
    assign bus.fp1_count     = outCount_q;
    assign bus.fp1_trunc     = outTrunc_q;
endmodule

// File: tb/tb_forward_propper_seq.sv
// Bench for forward_propper_seq: directed cases with literal results, then random
// beats, all cross-checked every cycle against a transaction-level neuron model.
module tb_forward_propper_seq;
    localparam int FRAC   = 16;
    localparam int MAX_IN = 4;
    localparam int CNTW   = 5;
    localparam logic signed [127:0] Z_HI = 128'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [127:0] Z_LO = -Z_HI - 128'sd1;

    logic clk;
    logic rstN;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   readyMode = 0;
    int   lastAcceptCyc = 0;
    int   validCyc = 0;

    forward_propper_seq_if #(.CNTW(CNTW)) bus ();

    forward_propper_seq #(
        .FRAC  (FRAC),
        .MAX_IN(MAX_IN),
        .CNTW  (CNTW)
    ) dut (
        .fp1_clk  (clk),
        .fp1_rst_n(rstN),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer side: 0 = always ready, 1 = random back-pressure, 2 = stalled.
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       bus.fp1_out_ready = 1'b1;
            1:       bus.fp1_out_ready = 1'($urandom_range(0, 1));
            default: bus.fp1_out_ready = 1'b0;
        endcase
    end

    task automatic compareField(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference neuron: a sum of beats evaluated with wide integer arithmetic.
    logic signed [127:0] mAcc;
    int                  mCount;
    bit                  mInSum, mBusy, mHasResult, started;
    int                  mAge;
    logic [31:0]         eA;
    logic [63:0]         eZ;
    bit                  eActive, eTrunc;
    int                  eCount;

    task automatic modelReset();
        mAcc = '0; mCount = 0; mInSum = 0; mBusy = 0; mHasResult = 0; mAge = 0;
        eA = '0; eZ = '0; eActive = 0; eTrunc = 0; eCount = 0;
    endtask

    task automatic modelBeat(input logic [31:0] p, input logic [31:0] w,
                             input logic [31:0] bias, input logic last);
        longint              pp;
        logic signed [127:0] bb;
        logic signed [127:0] z;
        pp = longint'($signed(p)) * longint'($signed(w));
        if (!mInSum) begin
            bb     = $signed(bias);
            mAcc   = (bb <<< FRAC) + pp;
            mCount = 1;
            mInSum = 1;
        end else begin
            mAcc   = mAcc + pp;
            mCount = mCount + 1;
        end
        if (last || mCount == MAX_IN) begin
            z = mAcc >>> FRAC;
            if (z > Z_HI) eZ = 64'h7FFF_FFFF_FFFF_FFFF;
            else if (z < Z_LO) eZ = 64'h8000_0000_0000_0000;
            else eZ = z[63:0];
            eActive    = (z > 0);
            eA         = !eActive ? 32'h0 : ((z > 128'sh7FFF_FFFF) ? 32'h7FFF_FFFF : z[31:0]);
            eCount     = mCount;
            eTrunc     = !last;
            mInSum     = 0;
            mBusy      = 1;
            mAge       = 0;
            mHasResult = 1;
        end
    endtask

    // Per-cycle compare against the model, then advance the model across the next edge.
    always @(negedge clk) begin
        bit expInReady, expOutValid;
        if (started) begin
            if (mBusy) mAge++;
            expInReady  = !mBusy;
            expOutValid = mBusy && (mAge >= 3);
            compareField("in_ready", 64'(bus.fp1_in_ready), 64'(expInReady));
            compareField("out_valid", 64'(bus.fp1_out_valid), 64'(expOutValid));
            if (expOutValid || !mHasResult) begin
                compareField("a", 64'(bus.fp1_a), 64'(eA));
                compareField("z", bus.fp1_z, eZ);
                compareField("active", 64'(bus.fp1_active), 64'(eActive));
                compareField("count", 64'(bus.fp1_count), 64'(eCount));
                compareField("trunc", 64'(bus.fp1_trunc), 64'(eTrunc));
            end
            if (!rstN) begin
                modelReset();
            end else if (expOutValid && bus.fp1_out_ready) begin
                mBusy = 0;
            end else if (expInReady && bus.fp1_in_valid) begin
                modelBeat(bus.fp1_p, bus.fp1_w, bus.fp1_bias, bus.fp1_last);
            end
        end else if (!rstN) begin
            modelReset();
            started = 1;
        end
    end

    task automatic applyStimulus(input logic [31:0] p, input logic [31:0] w,
                                 input logic [31:0] bias, input logic last);
        int budget;
        budget = 0;
        bus.fp1_in_valid = 1'b1;
        bus.fp1_p        = p;
        bus.fp1_w        = w;
        bus.fp1_bias     = bias;
        bus.fp1_last     = last;
        while (1) begin
            @(negedge clk);
            if (bus.fp1_in_ready) break;
            budget++;
            if (budget > 200) begin
                compareField("accept_timeout", 64'(budget), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        lastAcceptCyc    = cyc;
        bus.fp1_in_valid = 1'b0;
        bus.fp1_last     = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] expA, input logic [63:0] expZ,
                               input logic expActive, input int expCount, input logic expTrunc);
        int budget;
        budget = 0;
        @(negedge clk);
        while (!bus.fp1_out_valid && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.fp1_out_valid) begin
            compareField({name, "_valid_timeout"}, 64'(bus.fp1_out_valid), 64'd1);
        end else begin
            validCyc = cyc;
            compareField({name, "_a"}, 64'(bus.fp1_a), 64'(expA));
            compareField({name, "_z"}, bus.fp1_z, expZ);
            compareField({name, "_active"}, 64'(bus.fp1_active), 64'(expActive));
            compareField({name, "_count"}, 64'(bus.fp1_count), 64'(expCount));
            compareField({name, "_trunc"}, 64'(bus.fp1_trunc), 64'(expTrunc));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string name);
        @(negedge clk);
        compareField({name, "_in_ready"}, 64'(bus.fp1_in_ready), 64'd1);
        compareField({name, "_out_valid"}, 64'(bus.fp1_out_valid), 64'd0);
        compareField({name, "_a"}, 64'(bus.fp1_a), 64'd0);
        compareField({name, "_z"}, bus.fp1_z, 64'd0);
        compareField({name, "_active"}, 64'(bus.fp1_active), 64'd0);
        compareField({name, "_count"}, 64'(bus.fp1_count), 64'd0);
        compareField({name, "_trunc"}, 64'(bus.fp1_trunc), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int budget;
        rstN             = 1'b0;
        bus.fp1_in_valid = 1'b0;
        bus.fp1_p        = '0;
        bus.fp1_w        = '0;
        bus.fp1_bias     = '0;
        bus.fp1_last     = 1'b0;
        readyMode        = 0;
        repeat (3) @(posedge clk);
        #1;
        rstN = 1'b1;
        checkIdle("reset");

        // Three-beat sum; the bias on later beats must be ignored.
        applyStimulus(32'h0001_0000, 32'h0002_0000, 32'h0, 1'b0);
        applyStimulus(32'h0000_8000, 32'h0004_0000, 32'h0777_0000, 1'b0);
        applyStimulus(32'hFFFF_0000, 32'h0001_0000, 32'h1234_0000, 1'b1);
        checkOutput("t1", 32'h0003_0000, 64'h0000_0000_0003_0000, 1'b1, 3, 1'b0);
        compareField("t1_latency", 64'(validCyc - lastAcceptCyc), 64'd2);

        applyStimulus(32'h0001_0000, 32'h0000_8000, 32'hFFFF_0000, 1'b1);
        checkOutput("t2", 32'h0, 64'hFFFF_FFFF_FFFF_8000, 1'b0, 1, 1'b0);

        applyStimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, 1'b0);
        applyStimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, 1'b1);
        checkOutput("t3", 32'h7FFF_FFFF, 64'h0000_7FFF_FFFE_0000, 1'b1, 2, 1'b0);

        // Stalled consumer while the next beat waits upstream.
        readyMode = 2;
        applyStimulus(32'h0002_0000, 32'h0001_0000, 32'h0, 1'b1);
        fork
            applyStimulus(32'h0001_0000, 32'h0003_0000, 32'h0, 1'b1);
            begin
                checkOutput("t4_first", 32'h0002_0000, 64'h0002_0000, 1'b1, 1, 1'b0);
                repeat (4) @(posedge clk);
                #1;
                checkOutput("t4_held", 32'h0002_0000, 64'h0002_0000, 1'b1, 1, 1'b0);
                @(negedge clk);
                compareField("t4_in_ready_held", 64'(bus.fp1_in_ready), 64'd0);
                readyMode = 0;
            end
        join
        checkOutput("t4_second", 32'h0003_0000, 64'h0003_0000, 1'b1, 1, 1'b0);

        // Force-termination at MAX_IN; beats 5 and 6 start a fresh sum.
        fork
            for (int i = 0; i < 6; i++) applyStimulus(32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0);
            checkOutput("t5", 32'h0004_0000, 64'h0004_0000, 1'b1, 4, 1'b1);
        join

        // Reset mid-sum discards the two pending beats.
        rstN = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        checkIdle("t6_reset");
        applyStimulus(32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
        checkOutput("t6", 32'h0001_0000, 64'h0001_0000, 1'b1, 1, 1'b0);

        // Random beats with random consumer back-pressure.
        readyMode = 1;
        for (int i = 0; i < 200; i++) begin
            logic [31:0] p, w, bias;
            if ($urandom_range(0, 3) == 0) begin
                p = $urandom;
                w = $urandom;
            end else begin
                p = 32'($urandom_range(0, 32'h3_FFFF)) - 32'h2_0000;
                w = 32'($urandom_range(0, 32'h3_FFFF)) - 32'h2_0000;
            end
            bias = 32'($urandom_range(0, 32'h7_FFFF)) - 32'h4_0000;
            applyStimulus(p, w, bias, ($urandom_range(0, 3) == 0) || (i == 199));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        budget = 0;
        while (mBusy && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        if (mBusy) compareField("drain_timeout", 64'(budget), 64'd0);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
